// File: rtl/ysyx_24090013_kv_table.sv
// ysyx_24090013_kv_table: register-based programmable key/data lookup table.
// Supports writes, single-key invalidate, multi-cycle flush, and a lookup
// path with a registered response.
// Optional macro YSYX_24090013_KV_BYPASS_EN makes a lookup see the result
// of a same-cycle accepted write or invalidate. The default build uses
// the pre-edge table contents.
//
// Handshake: a write is accepted on a rising edge where wr_valid && wr_ready.
// wr_ready is high only in IDLE. An IDLE write or invalidate that arrives in
// the same cycle as flush is dropped. Invalidate and lookup have no ready;
// they are sampled on every edge. busy mirrors the FSM state (1 = FLUSH).
module ysyx_24090013_kv_table #(
    parameter int NR_KEY   = 4,
    parameter int KEY_LEN  = 8,
    parameter int DATA_LEN = 32,
    localparam int CW      = $clog2(NR_KEY + 1),
    localparam int IW      = $clog2(NR_KEY)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_valid,
    output logic                wr_ready,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                inv_valid,
    input  logic [KEY_LEN-1:0]  inv_key,
    input  logic                flush,
    input  logic                lk_valid,
    input  logic [KEY_LEN-1:0]  lk_key,
    output logic                rsp_valid,
    output logic                rsp_hit,
    output logic [DATA_LEN-1:0] rsp_data,
    output logic [CW-1:0]       count,
    output logic                full,
    output logic                busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [IW-1:0]       rr_q, rr_d;
    logic [NR_KEY-1:0]   valid_q, valid_d;
    logic [CW-1:0]       count_q, count_d;
    logic [KEY_LEN-1:0]  key_q  [NR_KEY];
    logic [DATA_LEN-1:0] data_q [NR_KEY];

    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_hit_q, rsp_hit_d;
    logic [DATA_LEN-1:0] rsp_data_q, rsp_data_d;

    logic                wr_fire, inv_fire;
    logic                wr_hit, inv_hit, lk_hit, free_any;
    logic [IW-1:0]       wr_hit_idx, inv_hit_idx, lk_idx, free_idx;
    logic                wr_en;
    logic [IW-1:0]       wr_slot;

    assign wr_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_FLUSH);
    assign wr_fire   = wr_valid && (state_q == S_IDLE) && !flush;
    assign inv_fire  = inv_valid && (state_q == S_IDLE) && !flush;
    assign count     = count_q;
    assign full      = (count_q == CW'(NR_KEY));
    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_data  = rsp_data_q;

    // Match all three keys against the pre-edge table and find the lowest free slot.
    always_comb begin
        wr_hit      = 1'b0;
        wr_hit_idx  = '0;
        inv_hit     = 1'b0;
        inv_hit_idx = '0;
        lk_hit      = 1'b0;
        lk_idx      = '0;
        free_any    = 1'b0;
        free_idx    = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            if (valid_q[i] && key_q[i] == wr_key) begin
                wr_hit     = 1'b1;
                wr_hit_idx = IW'(i);
            end
            if (valid_q[i] && key_q[i] == inv_key) begin
                inv_hit     = 1'b1;
                inv_hit_idx = IW'(i);
            end
            if (valid_q[i] && key_q[i] == lk_key) begin
                lk_hit = 1'b1;
                lk_idx = IW'(i);
            end
            if (!valid_q[i] && !free_any) begin
                free_any = 1'b1;
                free_idx = IW'(i);
            end
        end
    end

    // FSM next state and valid-bit updates. The invalidate is applied before
    // the write, so a write to the same key leaves the entry valid.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        valid_d = valid_q;
        wr_en   = 1'b0;
        wr_slot = rr_q;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    state_d = S_FLUSH;
                    idx_d   = '0;
                end else begin
                    if (inv_fire && inv_hit) begin
                        valid_d[inv_hit_idx] = 1'b0;
                    end
                    if (wr_fire) begin
                        wr_en = 1'b1;
                        if (wr_hit) begin
                            wr_slot = wr_hit_idx;
                        end else if (free_any) begin
                            wr_slot = free_idx;
                        end else begin
                            wr_slot = rr_q;
                            rr_d    = (rr_q == IW'(NR_KEY - 1)) ? '0 : rr_q + IW'(1);
                        end
                        valid_d[wr_slot] = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                valid_d[idx_q] = 1'b0;
                if (idx_q == IW'(NR_KEY - 1)) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                    rr_d    = '0;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Count the number of valid entries in the post-edge table.
    always_comb begin
        count_d = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            count_d = count_d + CW'(valid_d[i]);
        end
    end

    // Lookup response. A lookup issued during a flush always misses.
    always_comb begin
        rsp_valid_d = lk_valid;
        rsp_hit_d   = 1'b0;
        rsp_data_d  = '0;
        if (lk_valid && state_q == S_IDLE) begin
            if (lk_hit) begin
                rsp_hit_d  = 1'b1;
                rsp_data_d = data_q[lk_idx];
            end
`ifdef YSYX_24090013_KV_BYPASS_EN
            if (inv_fire && lk_key == inv_key) begin
                rsp_hit_d  = 1'b0;
                rsp_data_d = '0;
            end
            if (wr_fire && lk_key == wr_key) begin
                rsp_hit_d  = 1'b1;
                rsp_data_d = wr_data;
            end
`endif
        end
    end

    // Control state, valid bits and response registers, with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            rr_q        <= '0;
            valid_q     <= '0;
            count_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rr_q        <= rr_d;
            valid_q     <= valid_d;
            count_q     <= count_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Key/data storage is not reset. Entries are qualified by their valid bits.
    always_ff @(posedge clk) begin
        if (rst_n && wr_en) begin
            key_q[wr_slot]  <= wr_key;
            data_q[wr_slot] <= wr_data;
        end
    end

endmodule
